// File: rtl/ndn_ram_arbiter.sv
// rtl/ndn_ram_arbiter.sv - round-robin burst arbiter for the shared single-port content RAM
//
// Purpose: grants whole read/write bursts to the PIT or FIB requester and
// sequences address, write enable and write data into the RAM. It returns
// read data to the burst owner with per-beat valid strobes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pit_* / fib_*            identical requester ports:
//     req, we, addr, len     burst request, direction, start address, beat count (0 = 2^ADDR_W)
//     wdata                  write beat data, valid whenever pop is high
//     gnt, pop, done         first-beat pulse, write beat consumed, last-beat pulse
//     rvalid, rdata          read beat return, one cycle after the beat's address
//   ram_addr, ram_we, ram_data, ram_q   single-port RAM connection (q registered)
//   busy                     high in every burst cycle
module ndn_ram_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pit_req,
    input  logic              pit_we,
    input  logic [ADDR_W-1:0] pit_addr,
    input  logic [ADDR_W-1:0] pit_len,
    input  logic [DATA_W-1:0] pit_wdata,
    output logic              pit_gnt,
    output logic              pit_pop,
    output logic              pit_rvalid,
    output logic [DATA_W-1:0] pit_rdata,
    output logic              pit_done,
    input  logic              fib_req,
    input  logic              fib_we,
    input  logic [ADDR_W-1:0] fib_addr,
    input  logic [ADDR_W-1:0] fib_len,
    input  logic [DATA_W-1:0] fib_wdata,
    output logic              fib_gnt,
    output logic              fib_pop,
    output logic              fib_rvalid,
    output logic [DATA_W-1:0] fib_rdata,
    output logic              fib_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic              owner_q;      // 0 = PIT, 1 = FIB
    logic              last_fib_q;   // last granted requester was FIB
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] beat_q;
    logic [ADDR_W-1:0] last_beat_q;  // len - 1; len 0 wraps to all ones = 2^ADDR_W beats
    logic [DATA_W-1:0] data_q;
    logic              pit_rv_q;
    logic              fib_rv_q;

    logic              in_burst;
    logic              last_beat;
    logic              start;
    logic              pick_fib;
    logic [DATA_W-1:0] owner_wdata;

    assign in_burst    = (state == BURST);
    assign last_beat   = (beat_q == last_beat_q);
    assign owner_wdata = owner_q ? fib_wdata : pit_wdata;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        pick_fib  = 1'b0;
        if (state == IDLE) begin
            if (pit_req || fib_req) begin
                start     = 1'b1;
                // On a tie the requester not granted last wins.
                pick_fib  = fib_req && (!pit_req || !last_fib_q);
                state_nxt = BURST;
            end
        end else begin
            if (last_beat) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner_q     <= 1'b0;
            last_fib_q  <= 1'b1;  // makes PIT win the first tie
            we_q        <= 1'b0;
            addr_q      <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
            data_q      <= '0;
            pit_rv_q    <= 1'b0;
            fib_rv_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pit_rv_q <= in_burst && !we_q && !owner_q;
            fib_rv_q <= in_burst && !we_q && owner_q;
            if (start) begin
                owner_q     <= pick_fib;
                we_q        <= pick_fib ? fib_we : pit_we;
                addr_q      <= pick_fib ? fib_addr : pit_addr;
                last_beat_q <= (pick_fib ? fib_len : pit_len) - ADDR_W'(1);
                beat_q      <= '0;
            end else if (in_burst) begin
                beat_q <= beat_q + ADDR_W'(1);
                // The address stays on the final beat so it holds while idle.
                if (!last_beat) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end else begin
                    last_fib_q <= owner_q;
                end
                if (we_q) begin
                    data_q <= owner_wdata;
                end
            end
        end
    end

    assign busy     = in_burst;
    assign ram_addr = addr_q;
    assign ram_we   = in_burst && we_q;
    assign ram_data = (in_burst && we_q) ? owner_wdata : data_q;

    assign pit_gnt  = in_burst && (beat_q == '0) && !owner_q;
    assign fib_gnt  = in_burst && (beat_q == '0) && owner_q;
    assign pit_pop  = in_burst && we_q && !owner_q;
    assign fib_pop  = in_burst && we_q && owner_q;
    assign pit_done = in_burst && last_beat && !owner_q;
    assign fib_done = in_burst && last_beat && owner_q;

    // ram_q is already the RAM's registered output for the previous cycle's
    // address, so it lines up with the registered valid strobes; gating keeps
    // rdata at zero between beats.
    assign pit_rvalid = pit_rv_q;
    assign fib_rvalid = fib_rv_q;
    assign pit_rdata  = pit_rv_q ? ram_q : '0;
    assign fib_rdata  = fib_rv_q ? ram_q : '0;

endmodule

// File: tb/tb_ndn_ram_arbiter.sv
// tb/tb_ndn_ram_arbiter.sv - randomized self-checking bench for ndn_ram_arbiter
module tb_ndn_ram_arbiter;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    logic pit_req, pit_we, fib_req, fib_we;
    logic [AW-1:0] pit_addr, pit_len, fib_addr, fib_len;
    logic [DW-1:0] pit_wdata, fib_wdata;
    logic pit_gnt, pit_pop, pit_rvalid, pit_done;
    logic fib_gnt, fib_pop, fib_rvalid, fib_done;
    logic [DW-1:0] pit_rdata, fib_rdata;
    logic [AW-1:0] ram_addr;
    logic ram_we, busy;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q = '0;

    always #5 clk = ~clk;

    ndn_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .pit_req(pit_req), .pit_we(pit_we), .pit_addr(pit_addr), .pit_len(pit_len),
        .pit_wdata(pit_wdata), .pit_gnt(pit_gnt), .pit_pop(pit_pop),
        .pit_rvalid(pit_rvalid), .pit_rdata(pit_rdata), .pit_done(pit_done),
        .fib_req(fib_req), .fib_we(fib_we), .fib_addr(fib_addr), .fib_len(fib_len),
        .fib_wdata(fib_wdata), .fib_gnt(fib_gnt), .fib_pop(fib_pop),
        .fib_rvalid(fib_rvalid), .fib_rdata(fib_rdata), .fib_done(fib_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data), .ram_q(ram_q),
        .busy(busy)
    );

    // Single-port RAM with registered read data.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    // Reference model: the burst currently scheduled, arbitration priority,
    // and the memory contents implied by all scheduled write beats.
    int   cyc;
    bit   b_act;
    int   b_own, b_base, b_n, b_start;
    bit   b_we;
    bit   tie_pit;
    int   last_addr;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wq_pit[$];
    logic [DW-1:0] wq_fib[$];
    bit   stg [2];
    bit   stg_we [2];
    int   stg_addr [2];
    int   stg_len [2];
    bit   drop [2];
    bit   rnd;

    int errors;
    int checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input int o, input bit r, input bit we, input int addr, input int len);
        if (o == 0) begin
            pit_req = r; pit_we = we; pit_addr = AW'(addr); pit_len = AW'(len);
        end else begin
            fib_req = r; fib_we = we; fib_addr = AW'(addr); fib_len = AW'(len);
        end
    endtask

    task automatic post(input int o, input bit we, input int addr, input int len);
        stg[o] = 1; stg_we[o] = we; stg_addr[o] = addr; stg_len[o] = len;
    endtask

    function automatic bit quiet();
        return !pit_req && !fib_req && !stg[0] && !stg[1] && !drop[0] && !drop[1]
               && !(b_act && cyc < b_start + b_n + 1);
    endfunction

    task automatic step(input bit do_rst);
        bit inb, rvb;
        int k, ea, ra, o;
        logic [DW-1:0] d;
        @(negedge clk);
        cyc++;
        rst = do_rst;
        if (do_rst) begin
            b_act = 0; tie_pit = 1; last_addr = 0;
        end
        inb = b_act && cyc >= b_start && cyc < b_start + b_n;
        k   = cyc - b_start;
        ea  = inb ? (b_base + k) % DEPTH : last_addr;
        rvb = b_act && !b_we && (cyc - 1 >= b_start) && (cyc - 1 < b_start + b_n);
        d   = '0;
        if (inb && b_we) begin
            if (b_own == 0) begin
                d = (wq_pit.size() > 0) ? wq_pit.pop_front() : DW'($urandom);
                pit_wdata = d;
            end else begin
                d = (wq_fib.size() > 0) ? wq_fib.pop_front() : DW'($urandom);
                fib_wdata = d;
            end
            ref_mem[ea] = d;
        end
        #1;
        check("pit_gnt", pit_gnt, inb && k == 0 && b_own == 0);
        check("fib_gnt", fib_gnt, inb && k == 0 && b_own == 1);
        check("pit_pop", pit_pop, inb && b_we && b_own == 0);
        check("fib_pop", fib_pop, inb && b_we && b_own == 1);
        check("pit_done", pit_done, inb && k == b_n - 1 && b_own == 0);
        check("fib_done", fib_done, inb && k == b_n - 1 && b_own == 1);
        check("pit_rvalid", pit_rvalid, rvb && b_own == 0);
        check("fib_rvalid", fib_rvalid, rvb && b_own == 1);
        check("busy", busy, inb);
        check("ram_we", ram_we, inb && b_we);
        check("ram_addr", ram_addr, ea);
        if (inb && b_we) check("ram_data", ram_data, d);
        if (rvb) begin
            ra = (b_base + cyc - 1 - b_start) % DEPTH;
            if (b_own == 0) check("pit_rdata", pit_rdata, ref_mem[ra]);
            else            check("fib_rdata", fib_rdata, ref_mem[ra]);
        end
        if (do_rst) begin
            check("rst_pit_rdata", pit_rdata, 0);
            check("rst_fib_rdata", fib_rdata, 0);
            check("rst_ram_data", ram_data, 0);
        end
        last_addr = ea;
        if (inb && k == b_n - 1) tie_pit = (b_own == 1);

        // Requesters: drop after being scheduled, apply directed posts, or act randomly.
        for (int i = 0; i < 2; i++) begin
            if (drop[i]) begin
                if (i == 0) pit_req = 0; else fib_req = 0;
                drop[i] = 0;
            end else if (stg[i]) begin
                drive(i, 1, stg_we[i], stg_addr[i], stg_len[i]);
                stg[i] = 0;
            end else if (rnd) begin
                if ((i == 0) ? pit_req : fib_req) begin
                    if ($urandom_range(15) == 0) begin
                        if (i == 0) pit_req = 0; else fib_req = 0;
                    end
                end else if ($urandom_range(3) == 0) begin
                    drive(i, 1, 1'($urandom_range(1)), int'($urandom_range(63)),
                          ($urandom_range(19) == 0) ? 0 : int'($urandom_range(6, 1)));
                end
            end
        end

        // Arbitration on an idle cycle, using the requests sampled this cycle.
        if (!do_rst && !(b_act && cyc < b_start + b_n) && (pit_req || fib_req)) begin
            o       = (pit_req && fib_req) ? (tie_pit ? 0 : 1) : (pit_req ? 0 : 1);
            b_act   = 1;
            b_own   = o;
            b_we    = (o == 1) ? fib_we : pit_we;
            b_base  = (o == 1) ? int'(fib_addr) : int'(pit_addr);
            b_n     = (o == 1) ? int'(fib_len) : int'(pit_len);
            if (b_n == 0) b_n = DEPTH;
            b_start = cyc + 1;
            drop[o] = 1;
        end
    endtask

    task automatic run_idle();
        int n;
        n = 0;
        do begin
            step(0);
            n++;
        end while (!quiet() && n < 300);
        if (!quiet()) check("drain_timeout", 1, 0);
    endtask

    initial begin
        int n;
        logic [DW-1:0] v;
        rst = 1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        pit_wdata = '0; fib_wdata = '0;
        cyc = 0; b_act = 0; b_own = 0; b_base = 0; b_n = 1; b_start = 0; b_we = 0;
        tie_pit = 1; last_addr = 0; rnd = 0; errors = 0; checks = 0;
        for (int i = 0; i < 2; i++) begin
            stg[i] = 0; drop[i] = 0; stg_we[i] = 0; stg_addr[i] = 0; stg_len[i] = 0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            v = DW'($urandom);
            ram_mem[i] = v;
            ref_mem[i] = v;
        end

        repeat (3) step(1);

        // Write A1,B2,C3 at 10, then read them back.
        wq_pit.push_back(8'hA1); wq_pit.push_back(8'hB2); wq_pit.push_back(8'hC3);
        post(0, 1, 10, 3);
        run_idle();
        post(0, 0, 10, 3);
        run_idle();

        // Simultaneous requests from reset, then two more ties.
        step(1); step(1);
        post(0, 1, 40, 2); post(1, 1, 50, 3);
        run_idle();
        post(0, 0, 40, 2); post(1, 0, 50, 3);
        run_idle();
        post(0, 0, 41, 1); post(1, 0, 51, 2);
        run_idle();

        // Address wrap-around and a full-depth burst.
        post(1, 0, 62, 4);
        run_idle();
        post(0, 1, 5, 0);
        run_idle();
        post(1, 0, 0, 0);
        run_idle();

        // Reset during beat 2 of a 5-beat write with a FIB read pending.
        post(0, 1, 20, 5);
        n = 0;
        do begin
            step(0);
            n++;
        end while (!(b_act && cyc == b_start) && n < 50);
        check("reset_setup", b_act && cyc == b_start, 1);
        post(1, 0, 20, 2);
        step(1);
        step(1);
        wq_pit.delete();
        run_idle();

        // Single-beat read.
        post(1, 0, 7, 1);
        run_idle();

        // Random traffic.
        rnd = 1;
        repeat (1500) step(0);
        rnd = 0;
        run_idle();
        run_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ndn_ram_arbiter.md
# ndn_ram_arbiter

Burst arbiter for the router's single-port content RAM. The RAM is shared between two requesters: the PIT port (stores and replays content bytes) and the FIB port (streams content out toward the data interface). The arbiter grants whole bursts round-robin and sequences address, write-enable and write data into the RAM. It returns registered read data to the owning requester with per-beat valid strobes. It sits between the PIT/FIB modules and `single_port_ram_module` in the `ndn` top.

## Interface
Parameters:
- `ADDR_W`, default 6: RAM address width. Also the width of the burst length field.
- `DATA_W`, default 8: RAM data width.

Ports (`x` ∈ {`pit`, `fib`}; each requester has an identical port set):
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `x_req`  in  1  burst request; held until `x_gnt`
- `x_we`  in  1  burst direction: 1 = write, 0 = read; sampled with request
- `x_addr`  in  ADDR_W  burst start address; sampled with request
- `x_len`  in  ADDR_W  beat count; 0 encodes 2^ADDR_W; sampled with request
- `x_wdata`  in  DATA_W  write beat data; must be valid whenever `x_pop` is high
- `x_gnt`  out  1  one-cycle pulse marking the first beat of this requester's burst
- `x_pop`  out  1  write beat consumed this cycle
- `x_rvalid`  out  1  `x_rdata` valid this cycle
- `x_rdata`  out  DATA_W  read beat data
- `x_done`  out  1  one-cycle pulse on the last beat of the burst
- `ram_addr`  out  ADDR_W  to RAM `addr`
- `ram_we`  out  1  to RAM `we`
- `ram_data`  out  DATA_W  to RAM `data`
- `ram_q`  in  DATA_W  from RAM `q`; registered, valid 1 cycle after address
- `busy`  out  1  burst in progress

## Operation
- FSM has two states, IDLE and BURST.
- IDLE:
  - If any `x_req` is high, choose the owner: a lone requester wins; if both request, the requester not granted last wins.
  - After reset, PIT has priority.
  - Latch the owner's `we`, `addr` and `len` (len 0 → 2^ADDR_W beats), clear the beat counter, and go to BURST.
- BURST, each cycle:
  - `ram_addr` = base + beat, modulo 2^ADDR_W (wraps 63→0 at default width).
  - Write burst: `ram_we`=1, `ram_data`=owner `x_wdata`, owner `x_pop`=1.
  - Read burst: `ram_we`=0, no pop.
  - Beat counter increments each cycle.
  - On the last beat, assert owner `x_done`, record the owner as last-granted, and return to IDLE.
- Read return: `x_rvalid` and `x_rdata` are registered copies of "read beat issued" and `ram_q`. They appear exactly 1 cycle after each read beat, including the cycle after BURST exits.
- The non-owner's `x_req` is ignored during BURST and stays pending. The owner must drop its request by the cycle after `x_done`, or it re-requests.
- A request withdrawn before grant is simply not served.
- Outside a burst, `ram_we`=0 and `ram_addr`/`ram_data` hold their last value. `x_pop`, `x_gnt` and `x_done` are 0 for the non-owner.
- `rst` at any time, including mid-burst:
  - State returns to IDLE, the burst is aborted with no `x_done`, and priority returns to PIT.
  - RAM contents written before reset are not restored.

## Timing
- Reset values: all `x_gnt`, `x_pop`, `x_rvalid`, `x_done` = 0; `x_rdata` = 0; `ram_addr` = 0; `ram_we` = 0; `ram_data` = 0; `busy` = 0.
- Request seen in IDLE at cycle t → BURST from t+1: `x_gnt`=1 and the first RAM beat at t+1.
- N-beat burst occupies cycles t+1 … t+N. `x_done` is at t+N; IDLE at t+N+1.
- Minimum gap between bursts is one IDLE cycle, so back-to-back bursts start at t+N+2.
- Read data: beat k issued at t+1+k → `x_rvalid` at t+2+k. The final `x_rvalid` at t+N+1 overlaps IDLE.
- For N=1, `x_gnt` and `x_done` are asserted in the same cycle.
- `busy` = 1 exactly in BURST cycles.

## Test plan
- Single write then read:
  - Stimulus: PIT writes len=3 at addr 10 with data A1,B2,C3 (one per pop), then reads len=3 at addr 10.
  - Required response: `pit_pop` high 3 cycles; `pit_rvalid` 3 cycles returning A1,B2,C3, each 1 cycle after its address; `pit_done` on the 3rd beat.
- Simultaneous requests from reset:
  - Stimulus: both requests raised in the same cycle.
  - Required response: PIT granted first; FIB granted at PIT-end+2; on the next tie, PIT wins again only if FIB was last granted.
- Wrap-around:
  - Stimulus: FIB reads len=4 at addr 62.
  - Required response: `ram_addr` sequence 62,63,0,1.
- len=0:
  - Stimulus: PIT write burst with len=0.
  - Required response: 64 beats covering all addresses; `busy` high 64 cycles.
- Reset mid-burst:
  - Stimulus: assert `rst` during beat 2 of a 5-beat write.
  - Required response: all outputs 0 immediately; no `pit_done`; a FIB request pending across reset is granted on the first IDLE cycle after reset release.
- Single-beat read:
  - Stimulus: FIB reads len=1.
  - Required response: `fib_gnt` and `fib_done` both high in the same cycle; `fib_rvalid` the next cycle, concurrent with IDLE.
